// File: rtl/product_accumulator.sv
// Batch accumulator: sums ACC_LEN 4-bit products, then holds the result until it is consumed.
// Define ACC_SATURATE_EN to saturate on overflow; the default build wraps modulo 2^ACC_W.
module product_accumulator #(
    parameter  int ACC_LEN = 4,
    parameter  int ACC_W   = 8,
    localparam int CNT_W   = $clog2(ACC_LEN + 1)
) (
    input  logic             CLK_0,
    input  logic             RSTN_0,
    input  logic [3:0]       P_0,
    input  logic             P_VALID_0,
    output logic             P_READY_0,
    input  logic             CLR_0,
    output logic [ACC_W-1:0] SUM_0,
    output logic             SUM_VALID_0,
    input  logic             SUM_READY_0,
    output logic             OVF_0,
    output logic [CNT_W-1:0] CNT_0
);

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    localparam logic [CNT_W-1:0] LEN_C = CNT_W'(ACC_LEN);

    state_t             r_state, w_state_nxt;
    logic [ACC_W-1:0]   r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_ovf;

    logic               w_accept;
    logic               w_clear;
    logic [CNT_W-1:0]   w_cnt_inc;
    logic               w_last;
    logic [ACC_W:0]     w_sum_ext;
    logic               w_ovf_add;
    logic [ACC_W-1:0]   w_acc_add;

    // CLR_0 suppresses acceptance so a product presented alongside it is dropped.
    assign w_accept  = P_VALID_0 & (r_state != DONE) & ~CLR_0;
    assign w_clear   = CLR_0 | ((r_state == DONE) & SUM_READY_0);
    assign w_cnt_inc = r_cnt + CNT_W'(1);
    assign w_last    = (w_cnt_inc == LEN_C);
    assign w_sum_ext = {1'b0, r_acc} + {{(ACC_W-3){1'b0}}, P_0};
    assign w_ovf_add = w_sum_ext[ACC_W];

`ifdef ACC_SATURATE_EN
    assign w_acc_add = w_ovf_add ? {ACC_W{1'b1}} : w_sum_ext[ACC_W-1:0];
`else
    assign w_acc_add = w_sum_ext[ACC_W-1:0];
`endif

    always_ff @(posedge CLK_0 or negedge RSTN_0) begin
        if (!RSTN_0) r_state <= IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (CLR_0) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE, ACCUM: if (w_accept) w_state_nxt = w_last ? DONE : ACCUM;
                DONE:        if (SUM_READY_0) w_state_nxt = IDLE;
                default:     w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK_0 or negedge RSTN_0) begin
        if (!RSTN_0) begin
            r_acc <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else if (w_clear) begin
            r_acc <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else if (w_accept) begin
            r_acc <= w_acc_add;
            r_cnt <= w_cnt_inc;
            r_ovf <= r_ovf | w_ovf_add;
        end
    end

    assign P_READY_0   = (r_state != DONE);
    assign SUM_VALID_0 = (r_state == DONE);
    assign SUM_0       = r_acc;
    assign OVF_0       = r_ovf;
    assign CNT_0       = r_cnt;

endmodule

// File: tb/tb_product_accumulator.sv
// Directed + randomized checks of product_accumulator in three configurations
// (defaults, ACC_W=4/ACC_LEN=2, ACC_LEN=1) against a plain-arithmetic batch model.
module tb_product_accumulator;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Default instance: ACC_LEN=4, ACC_W=8
    logic [3:0] d_p;   logic d_pv, d_rdy, d_clr, d_sv, d_sr, d_ovf;
    logic [7:0] d_sum; logic [2:0] d_cnt;
    // Narrow instance: ACC_LEN=2, ACC_W=4
    logic [3:0] n_p;   logic n_pv, n_rdy, n_clr, n_sv, n_sr, n_ovf;
    logic [3:0] n_sum; logic [1:0] n_cnt;
    // Single-product instance: ACC_LEN=1, ACC_W=8
    logic [3:0] o_p;   logic o_pv, o_rdy, o_clr, o_sv, o_sr, o_ovf;
    logic [7:0] o_sum; logic [0:0] o_cnt;

    product_accumulator u_d (
        .CLK_0(clk), .RSTN_0(rstn), .P_0(d_p), .P_VALID_0(d_pv), .P_READY_0(d_rdy),
        .CLR_0(d_clr), .SUM_0(d_sum), .SUM_VALID_0(d_sv), .SUM_READY_0(d_sr),
        .OVF_0(d_ovf), .CNT_0(d_cnt));

    product_accumulator #(.ACC_LEN(2), .ACC_W(4)) u_n (
        .CLK_0(clk), .RSTN_0(rstn), .P_0(n_p), .P_VALID_0(n_pv), .P_READY_0(n_rdy),
        .CLR_0(n_clr), .SUM_0(n_sum), .SUM_VALID_0(n_sv), .SUM_READY_0(n_sr),
        .OVF_0(n_ovf), .CNT_0(n_cnt));

    product_accumulator #(.ACC_LEN(1), .ACC_W(8)) u_o (
        .CLK_0(clk), .RSTN_0(rstn), .P_0(o_p), .P_VALID_0(o_pv), .P_READY_0(o_rdy),
        .CLR_0(o_clr), .SUM_0(o_sum), .SUM_VALID_0(o_sv), .SUM_READY_0(o_sr),
        .OVF_0(o_ovf), .CNT_0(o_cnt));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic d_accept(input logic [3:0] v);
        d_p = v; d_pv = 1'b1;
        tick();
        d_pv = 1'b0;
    endtask

    // Batch result for a 4-bit accumulator: true sum, then wrap or saturate.
    function automatic void w4_model(input int a, input int b, output int s, output int o);
        int t;
        t = a + b;
        o = (t > 15) ? 1 : 0;
`ifdef ACC_SATURATE_EN
        s = (t > 15) ? 15 : t;
`else
        s = t % 16;
`endif
    endfunction

    initial begin
        int q[$];
        int tot, es, eo, a, b;
        logic [7:0] held;

        rstn = 1'b0;
        d_p = '0; d_pv = 0; d_clr = 0; d_sr = 0;
        n_p = '0; n_pv = 0; n_clr = 0; n_sr = 0;
        o_p = '0; o_pv = 0; o_clr = 0; o_sr = 0;
        #3;
        chk("rst_sum",  32'(d_sum), 0);
        chk("rst_sv",   32'(d_sv),  0);
        chk("rst_ovf",  32'(d_ovf), 0);
        chk("rst_cnt",  32'(d_cnt), 0);
        chk("rst_rdy",  32'(d_rdy), 1);
        @(negedge clk); rstn = 1'b1;
        tick();

        // Basic batch 0,6,3,0
        d_accept(0); d_accept(6); d_accept(3);
        chk("b1_sv_early", 32'(d_sv), 0);
        d_accept(0);
        chk("b1_sv",  32'(d_sv),  1);
        chk("b1_sum", 32'(d_sum), 9);
        chk("b1_ovf", 32'(d_ovf), 0);
        chk("b1_cnt", 32'(d_cnt), 4);

        // Backpressure: result held, products ignored
        d_pv = 1'b1; d_p = 4'd15;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_sum", 32'(d_sum), 9);
            chk("bp_rdy", 32'(d_rdy), 0);
            chk("bp_cnt", 32'(d_cnt), 4);
        end
        d_sr = 1'b1;
        tick();
        d_sr = 1'b0; d_pv = 1'b0;
        chk("hs_rdy", 32'(d_rdy), 1);
        chk("hs_sv",  32'(d_sv),  0);
        chk("hs_cnt", 32'(d_cnt), 0);
        chk("hs_sum", 32'(d_sum), 0);

        // Clear discards partial batch and the product presented with it
        d_accept(6); d_accept(6);
        d_clr = 1'b1; d_pv = 1'b1; d_p = 4'd9;
        tick();
        d_clr = 1'b0; d_pv = 1'b0;
        chk("clr_cnt", 32'(d_cnt), 0);
        chk("clr_sum", 32'(d_sum), 0);
        for (int i = 0; i < 4; i++) d_accept(1);
        chk("clr_b_sum", 32'(d_sum), 4);
        chk("clr_b_ovf", 32'(d_ovf), 0);
        chk("clr_b_sv",  32'(d_sv),  1);

        // Clear in DONE drops the result without a handshake
        d_clr = 1'b1;
        tick();
        d_clr = 1'b0;
        chk("clrdone_sv",  32'(d_sv),  0);
        chk("clrdone_rdy", 32'(d_rdy), 1);

        // Asynchronous reset mid-batch
        d_accept(5); d_accept(7);
        chk("pre_rst_sum", 32'(d_sum), 12);
        chk("pre_rst_cnt", 32'(d_cnt), 2);
        #2 rstn = 1'b0;
        #1;
        chk("arst_cnt", 32'(d_cnt), 0);
        chk("arst_sum", 32'(d_sum), 0);
        chk("arst_sv",  32'(d_sv),  0);
        #1 rstn = 1'b1;
        tick();
        chk("arst_sv2", 32'(d_sv), 0);
        d_accept(2); d_accept(2); d_accept(2);
        chk("arst_sv3", 32'(d_sv), 0);
        d_accept(2);
        chk("arst_newsum", 32'(d_sum), 8);
        d_sr = 1'b1; tick(); d_sr = 1'b0;

        // Random batches with valid gaps on the default instance
        for (int bt = 0; bt < 8; bt++) begin
            q.delete();
            while (q.size() < 4) begin
                d_pv = 1'($urandom_range(0, 1));
                d_p  = 4'($urandom_range(0, 15));
                tick();
                if (d_pv) q.push_back(int'(d_p));
                chk("rnd_cnt", 32'(d_cnt), q.size());
                chk("rnd_sv",  32'(d_sv),  (q.size() == 4) ? 1 : 0);
            end
            d_pv = 1'b0;
            tot = 0;
            foreach (q[k]) tot += q[k];
            chk("rnd_sum", 32'(d_sum), tot);
            chk("rnd_ovf", 32'(d_ovf), 0);
            held = d_sum;
            tick();
            chk("rnd_hold", 32'(d_sum), 32'(held));
            d_sr = 1'b1; tick(); d_sr = 1'b0;
            chk("rnd_hs_cnt", 32'(d_cnt), 0);
        end

        // Narrow instance: directed 9,9 overflow, then random pairs
        for (int bt = 0; bt < 17; bt++) begin
            a = (bt == 0) ? 9 : int'($urandom_range(0, 15));
            b = (bt == 0) ? 9 : int'($urandom_range(0, 15));
            w4_model(a, b, es, eo);
            n_pv = 1'b1; n_p = 4'(a); tick();
            n_p = 4'(b); tick();
            n_pv = 1'b0;
            chk("w4_sv",  32'(n_sv),  1);
            chk("w4_sum", 32'(n_sum), es);
            chk("w4_ovf", 32'(n_ovf), eo);
            n_sr = 1'b1; tick(); n_sr = 1'b0;
            chk("w4_clr_ovf", 32'(n_ovf), 0);
        end

        // ACC_LEN=1 streaming: accept / DONE / IDLE repeating
        o_pv = 1'b1; o_p = 4'd3; o_sr = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (i % 2 == 0) begin
                chk("l1_sv",  32'(o_sv),  1);
                chk("l1_sum", 32'(o_sum), 3);
                chk("l1_rdy", 32'(o_rdy), 0);
            end else begin
                chk("l1_idle_sv",  32'(o_sv),  0);
                chk("l1_idle_cnt", 32'(o_cnt), 0);
                chk("l1_idle_rdy", 32'(o_rdy), 1);
            end
        end
        o_pv = 1'b0; o_sr = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/product_accumulator.md
PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

Interface
REQ-001 Parameter ACC_LEN, default 4: number of products summed per batch; legal range >= 1.
REQ-002 Parameter ACC_W, default 8: accumulator and result width; legal range >= 4.
REQ-003 Derived width CNT_W = clog2(ACC_LEN+1); it is not a user parameter.
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-005 CLK_0  input  1  clock; all state updates on its rising edge.
REQ-006 RSTN_0  input  1  asynchronous, active-low reset.
REQ-007 P_0  input  4  unsigned product from the upstream 2x2 multiplier.
REQ-008 P_VALID_0  input  1  P_0 carries a product to be accepted.
REQ-009 P_READY_0  output  1  block can accept a product this cycle.
REQ-010 CLR_0  input  1  synchronous batch abort/clear.
REQ-011 SUM_0  output  ACC_W  accumulated batch result.
REQ-012 SUM_VALID_0  output  1  SUM_0 holds a completed batch.
REQ-013 SUM_READY_0  input  1  downstream consumes SUM_0.
REQ-014 OVF_0  output  1  sticky overflow flag for the current batch.
REQ-015 CNT_0  output  CNT_W  number of products accepted in the current batch.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, ACCUM and DONE.
REQ-017 P_READY_0 SHALL be 1 in IDLE and ACCUM and 0 in DONE, driven from registered state only.
REQ-018 A product SHALL be accepted on a rising edge where P_VALID_0=1 and P_READY_0=1.
REQ-019 On acceptance, the accumulator SHALL add zero-extended P_0 and CNT_0 SHALL increment.
REQ-020 Transitions SHALL be: IDLE->ACCUM on an accept when ACC_LEN>1; ACCUM->DONE on the accept that makes CNT_0=ACC_LEN; IDLE->DONE directly on an accept when ACC_LEN=1.
REQ-021 SUM_VALID_0 SHALL assert on the cycle after the final accept (latency 1) and remain asserted, with SUM_0, OVF_0 and CNT_0 stable, until SUM_READY_0=1.
REQ-022 On the DONE handshake (SUM_VALID_0 & SUM_READY_0), the accumulator, CNT_0 and OVF_0 SHALL clear and the state SHALL return to IDLE; P_READY_0 reasserts the next cycle.
REQ-023 While in DONE, P_VALID_0 and P_0 SHALL be ignored.
REQ-024 SUM_0 SHALL always show the accumulator register; it is meaningful only while SUM_VALID_0=1.
REQ-025 If accumulator + P_0 > 2^ACC_W-1, OVF_0 SHALL set and stay set until the batch clears.
REQ-026 CLR_0=1 SHALL have priority over everything except reset: the accumulator, CNT_0 and OVF_0 clear, the state goes to IDLE, and any product presented that cycle is discarded.
REQ-027 A CLR_0 issued in DONE SHALL drop SUM_VALID_0 on the next cycle without requiring a handshake.

Reset
REQ-028 RSTN_0=0 SHALL immediately, without waiting for a clock edge, force state IDLE, SUM_0=0, SUM_VALID_0=0, OVF_0=0, CNT_0=0 and P_READY_0=1 (the IDLE value).
REQ-029 Reset asserted mid-batch SHALL discard all partial state; the first accept after release starts a new batch.

Configuration
REQ-030 Macro ACC_SATURATE_EN SHALL select the overflow policy.
REQ-031 With ACC_SATURATE_EN defined, an overflowing add SHALL leave the accumulator at 2^ACC_W-1 and later adds in the batch SHALL keep it there.
REQ-032 Without ACC_SATURATE_EN, the accumulator SHALL wrap modulo 2^ACC_W; OVF_0 behaviour is identical in both builds.

Verification
REQ-033 Defaults; accept products 0,6,3,0 -> SUM_0=9 and SUM_VALID_0=1 one cycle after the 4th accept, OVF_0=0, CNT_0=4.
REQ-034 Completed batch with SUM_READY_0 held low 3 cycles and P_VALID_0=1 -> SUM_0 stable, P_READY_0=0, no product accepted; release -> IDLE and P_READY_0=1 next cycle.
REQ-035 ACC_W=4, ACC_LEN=2, products 9,9 -> without macro SUM_0=2, OVF_0=1; with ACC_SATURATE_EN SUM_0=15, OVF_0=1.
REQ-036 Accept 6,6, then CLR_0 with P_VALID_0=1, P_0=9, then accept 1,1,1,1 -> SUM_0=4, OVF_0=0.
REQ-037 Accept 2 products, then drive RSTN_0 low between clock edges -> CNT_0=0 and SUM_0=0 before the next edge, SUM_VALID_0 stays 0.
REQ-038 ACC_LEN=1, P_VALID_0 held at 1 with P_0=3, SUM_READY_0=1 -> repeating accept/DONE/IDLE cycle, each SUM_0=3.
